// File: rtl/wb_mem_slave.sv
// ---------------------------------------------------------------------------
// wb_mem_slave
//   Wishbone classic-cycle SRAM target. Word-addressed memory window at
//   BASE_ADDR spanning DEPTH_WORDS 32-bit words, byte-lane writes, a fixed
//   number of wait states before termination, and an error termination for
//   addresses outside the window. Every accepted request ends in exactly one
//   ack or err pulse, followed by a dead cycle back in IDLE.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous, active-low reset
//   wb_adr_i  byte address ([1:0] ignored)
//   wb_dat_i  write data, lane-aligned
//   wb_sel_i  byte enables, bit i -> dat[8i+7:8i]
//   wb_we_i   1 = write, 0 = read
//   wb_cyc_i  bus cycle valid
//   wb_stb_i  strobe; request = cyc & stb
//   wb_dat_o  read data, valid while wb_ack_o is high
//   wb_ack_o  normal termination pulse
//   wb_err_o  error termination pulse
// ---------------------------------------------------------------------------
module wb_mem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Window end computed in 33 bits so a window at the top of the address
    // space does not wrap to zero.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          hit_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic          in_hit;

    // Access performed at the edge that enters RESP.
    logic          acc_fire;
    logic          acc_hit;
    logic          acc_we;
    logic [31:0]   acc_adr;
    logic [31:0]   acc_dat;
    logic [3:0]    acc_sel;
    logic [AW-1:0] acc_idx;

    function automatic logic addr_hit(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    assign req    = wb_cyc_i & wb_stb_i;
    assign in_hit = addr_hit(wb_adr_i);

    // With zero wait states the access happens on the same edge that accepts
    // the request, so it uses the live bus inputs instead of the latched copy.
    always_comb begin
        acc_fire = 1'b0;
        acc_hit  = hit_q;
        acc_we   = we_q;
        acc_adr  = adr_q;
        acc_dat  = dat_q;
        acc_sel  = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && (WAIT_STATES == 0)) begin
                    acc_fire = 1'b1;
                    acc_hit  = in_hit;
                    acc_we   = wb_we_i;
                    acc_adr  = wb_adr_i;
                    acc_dat  = wb_dat_i;
                    acc_sel  = wb_sel_i;
                end
            end
            S_WAIT: begin
                if (req && (cnt_q == 4'd1)) begin
                    acc_fire = 1'b1;
                end
            end
            default: ;
        endcase
        // Never touch memory while reset is held.
        if (!rst) begin
            acc_fire = 1'b0;
        end
        acc_idx = AW'((acc_adr - BASE_ADDR) >> 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            hit_q    <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        adr_q   <= wb_adr_i;
                        dat_q   <= wb_dat_i;
                        sel_q   <= wb_sel_i;
                        we_q    <= wb_we_i;
                        hit_q   <= in_hit;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Terminating edge overrides the state-local transitions above.
            if (acc_fire) begin
                state_q  <= S_RESP;
                wb_ack_o <= acc_hit;
                wb_err_o <= !acc_hit;
                if (!acc_hit) begin
                    wb_dat_o <= '0;
                end else if (!acc_we) begin
                    wb_dat_o <= mem_q[acc_idx];
                end
            end
        end
    end

    // Memory array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_hit && acc_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;

    localparam logic [31:0] BASE1  = 32'h1000_0000;
    localparam int          DEPTH1 = 64;
    localparam int          W1     = 1;
    localparam logic [31:0] BASE3  = 32'h0000_0000;
    localparam int          DEPTH3 = 16;
    localparam int          W3     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        use3 = 1'b0;

    logic        cyc1, cyc3;
    logic [31:0] dat1, dat3;
    logic        ack1, ack3, err1, err3;

    assign cyc1 = cyc & ~use3;
    assign cyc3 = cyc & use3;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    logic [31:0] ref_mem [DEPTH1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_mem_slave #(
        .DEPTH_WORDS(DEPTH1),
        .WAIT_STATES(W1),
        .BASE_ADDR  (BASE1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc1), .wb_stb_i(stb),
        .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1)
    );

    wb_mem_slave #(
        .DEPTH_WORDS(DEPTH3),
        .WAIT_STATES(W3),
        .BASE_ADDR  (BASE3)
    ) dut3 (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc3), .wb_stb_i(stb),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE1)) && (la < longint'(BASE1) + 4 * DEPTH1);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE1)) / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        int k;
        k = model_idx(a);
        w = ref_mem[k];
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[k] = w;
    endtask

    // One transfer on the selected DUT; reports the number of edges from the
    // first sampling edge to the termination, and checks the pulse ends.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic [31:0] rd, output logic ak,
                        output logic er, output int lat);
        @(negedge clk);
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        lat = 0; ak = 1'b0; er = 1'b0; rd = '0;
        while (!ak && !er && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ak = use3 ? ack3 : ack1;
            er = use3 ? err3 : err1;
            rd = use3 ? dat3 : dat1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("pulse_end", {30'd0, (use3 ? ack3 : ack1), (use3 ? err3 : err1)}, 32'd0);
    endtask

    task automatic run_chk(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w, input logic e_ack,
                           input logic e_err, input logic c_dat, input logic [31:0] e_dat,
                           input int e_lat);
        logic [31:0] rd;
        logic ak, er;
        int lat;
        xfer(a, d, s, w, rd, ak, er, lat);
        chk({nm, "_ack"}, {31'd0, ak}, {31'd0, e_ack});
        chk({nm, "_err"}, {31'd0, er}, {31'd0, e_err});
        chk({nm, "_lat"}, lat, e_lat);
        if (c_dat) chk({nm, "_dat"}, rd, e_dat);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        e_ack;
        logic        e_err;
        logic        c_dat;
        logic [31:0] e_dat;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic w, input logic ea, input logic ee,
                                input logic cd, input logic [31:0] ed);
        vec_t v;
        v.adr = a; v.dat = d; v.sel = s; v.we = w;
        v.e_ack = ea; v.e_err = ee; v.c_dat = cd; v.e_dat = ed;
        return v;
    endfunction

    initial begin
        vec_t vecs [13];
        logic [31:0] a, d, rd, d1, d2, known;
        logic [3:0] s;
        logic w, h, ak, er;
        int lat, t1, t2, n, k, r;
        logic seen;

        vecs[0]  = mk(BASE1 + 32'h10,     32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[1]  = mk(BASE1 + 32'h10,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs[2]  = mk(BASE1 + 32'h10,     32'h00AA_0000, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[3]  = mk(BASE1 + 32'h10,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAA_BEEF);
        vecs[4]  = mk(BASE1 + 32'h100,    '0,            4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        vecs[5]  = mk(BASE1 + 32'h10,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAA_BEEF);
        vecs[6]  = mk(BASE1 + 32'h10,     32'hFFFF_FFFF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[7]  = mk(BASE1 + 32'h10,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAA_BEEF);
        vecs[8]  = mk(BASE1 - 32'h4,      32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        vecs[9]  = mk(BASE1 + 32'hFC,     32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[10] = mk(BASE1 + 32'hFC,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        vecs[11] = mk(BASE1 + 32'h1_0010, '0,            4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        vecs[12] = mk(BASE1 + 32'h13,     '0,            4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAA_BEEF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_dat1", dat1, 32'd0);
        chk("rst_ack3", {31'd0, ack3}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Directed vectors on the single-wait-state instance
        use3 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            run_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we,
                    vecs[i].e_ack, vecs[i].e_err, vecs[i].c_dat, vecs[i].e_dat, 1 + W1);
        end

        // Randomised traffic against the reference memory
        for (int i = 0; i < DEPTH1; i++) begin
            d = $urandom();
            xfer(BASE1 + 32'(4 * i), d, 4'hF, 1'b1, rd, ak, er, lat);
            ref_mem[i] = d;
            chk($sformatf("fill%0d_ack", i), {31'd0, ak}, 32'd1);
        end
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      a = BASE1 + 32'(4 * $urandom_range(0, DEPTH1 - 1)) + 32'($urandom_range(0, 3));
            else if (r == 7) a = BASE1 + 32'h100 + 32'(4 * $urandom_range(0, 3));
            else if (r == 8) a = BASE1 - 32'(4 * (1 + $urandom_range(0, 3)));
            else             a = $urandom();
            d = $urandom();
            s = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            h = model_hit(a);
            if (h && !w)
                run_chk($sformatf("rnd%0d", i), a, d, s, w, 1'b1, 1'b0, 1'b1, ref_mem[model_idx(a)], 1 + W1);
            else
                run_chk($sformatf("rnd%0d", i), a, d, s, w, h, !h, !h, 32'h0, 1 + W1);
            if (h && w) model_write(a, d, s);
        end

        // Back-to-back reads with cyc/stb held high
        @(negedge clk);
        adr = BASE1 + 32'h40; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        n = 0;
        while (!ack1 && n < 20) begin @(posedge clk); #1; n++; end
        t1 = cyc_cnt; d1 = dat1;
        adr = BASE1 + 32'h44;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack1 && n < 20);
        t2 = cyc_cnt; d2 = dat1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("b2b_datA", d1, ref_mem[16]);
        chk("b2b_datB", d2, ref_mem[17]);
        chk("b2b_gap", t2 - t1, 2 + W1);
        chk("b2b_after", {30'd0, ack1, err1}, 32'd0);

        // Reset in the middle of a write's wait state
        known = 32'h5A5A_1234;
        run_chk("pre_rst_wr", BASE1 + 32'h20, known, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1 + W1);
        ref_mem[8] = known;
        run_chk("pre_rst_rd", BASE1 + 32'h20, '0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, known, 1 + W1);
        @(negedge clk);
        adr = BASE1 + 32'h20; dat = ~known; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rstw_ack", {31'd0, ack1}, 32'd0);
        chk("rstw_err", {31'd0, err1}, 32'd0);
        chk("rstw_dat", dat1, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        run_chk("rstw_after", BASE1 + 32'h20, '0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, known, 1 + W1);

        // Reset while ack is being driven: outputs clear without a clock edge
        @(negedge clk);
        adr = BASE1 + 32'h20; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        n = 0;
        while (!ack1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("rsta_pre_dat", dat1, known);
        rst = 1'b0; #1;
        chk("rsta_ack", {31'd0, ack1}, 32'd0);
        chk("rsta_dat", dat1, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b1;
        run_chk("rsta_after", BASE1 + 32'h24, '0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, ref_mem[9], 1 + W1);

        // Three-wait-state instance: aborted write
        use3 = 1'b1;
        run_chk("w3_wr", BASE3 + 32'h8, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1 + W3);
        @(negedge clk);
        adr = BASE3 + 32'h8; dat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 2; j++) begin @(posedge clk); #1; seen = seen | ack3 | err3; end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1; seen = seen | ack3 | err3;
        chk("abort_noresp", {31'd0, seen}, 32'd0);
        run_chk("abort_rd", BASE3 + 32'h8, '0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1 + W3);
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin @(posedge clk); #1; seen = seen | ack3 | err3; end
        chk("abort_quiet", {31'd0, seen}, 32'd0);
        run_chk("w3_miss", BASE3 + 32'h40, '0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1 + W3);
        use3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d checks failed so far", fails, tests);
        $fatal(1);
    end

endmodule
